// File: rtl/sys_bridge_pkg.sv
// Shared constants and FSM encoding for the CPU-to-peripheral bridge.
// The address-map defaults are also used by the CPU's address-range exception checks.
package sys_bridge_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int          IRQ_W         = 6;
  localparam logic [31:0] DEF_BASE      = 32'h0000_7F00;
  localparam logic [31:0] DEF_STRIDE    = 32'h10;
  localparam int          DEF_WIN_BYTES = 12;
  localparam int          DEF_WR_BYTES  = 8;

endpackage

// File: rtl/irq_latch_n.sv
// Per-device interrupt conditioning: one register stage on the raw line, then
// either a registered level or a sticky rising-edge latch cleared by the bridge.
import sys_bridge_pkg::*;

module irq_latch_n #(
  parameter int                 NUM_DEV  = 4,
  parameter logic [NUM_DEV-1:0] IRQ_EDGE = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_DEV-1:0] irq_in,
  input  logic [NUM_DEV-1:0] clr,
  output logic [NUM_DEV-1:0] irq
);

  for (genvar i = 0; i < NUM_DEV; i++) begin : g_dev
    logic q, d, o;

    // A rise arriving in the clearing cycle keeps the latch set.
    always_ff @(posedge clk) begin
      if (reset) begin
        q <= 1'b0;
        d <= 1'b0;
        o <= 1'b0;
      end else begin
        q <= irq_in[i];
        d <= q;
        o <= IRQ_EDGE[i] ? ((o & ~clr[i]) | (q & ~d)) : q;
      end
    end

    assign irq[i] = o;
  end

endmodule

// File: rtl/sys_bridge_n.sv
// Bridge from the CPU memory stage to NUM_DEV memory-mapped peripherals with
// wait-state handshake, access timeout, decode/permission errors and IRQ aggregation.
import sys_bridge_pkg::*;

module sys_bridge_n #(
  parameter int                 NUM_DEV   = 4,
  parameter logic [31:0]        BASE      = DEF_BASE,
  parameter logic [31:0]        STRIDE    = DEF_STRIDE,
  parameter int                 WIN_BYTES = DEF_WIN_BYTES,
  parameter int                 WR_BYTES  = DEF_WR_BYTES,
  parameter int                 TIMEOUT   = 16,
  parameter logic [NUM_DEV-1:0] IRQ_EDGE  = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_be,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    cpu_err,
  output logic [IRQ_W-1:0]        irq_out,
  output logic [NUM_DEV-1:0]      dev_sel,
  output logic                    dev_we,
  output logic [3:0]              dev_addr,
  output logic [31:0]             dev_wdata,
  output logic [3:0]              dev_be,
  input  logic [32*NUM_DEV-1:0]   dev_rdata,
  input  logic [NUM_DEV-1:0]      dev_ack,
  input  logic [NUM_DEV-1:0]      dev_irq
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_t             state, nxt;
  logic               we_q, err_q;
  logic [3:0]         addr_q, be_q;
  logic [31:0]        wdata_q, rdata_q, rd_mux, off;
  logic [NUM_DEV-1:0] sel_q, hit, clr, irq_dev;
  logic [CW-1:0]      cnt;
  logic               found, ack_hit, tmo, in_acc;

  // Unsigned wrap makes addresses below BASE decode far out of range.
  // First match wins so the select stays one-hot even with overlapping windows.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      off = cpu_addr - BASE - 32'(i) * STRIDE;
      if (!found && off < 32'(WIN_BYTES) && (!cpu_we || off < 32'(WR_BYTES))) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_DEV; i++)
      if (sel_q[i]) rd_mux = rd_mux | dev_rdata[32*i +: 32];
  end

  assign in_acc  = (state == S_ACCESS);
  assign ack_hit = |(dev_ack & sel_q);
  assign tmo     = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (cpu_req) nxt = found ? S_ACCESS : S_RESP;
      S_ACCESS: if (ack_hit || tmo) nxt = S_RESP;
      S_RESP:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: if (cpu_req) begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr[3:0];
          wdata_q <= cpu_wdata;
          be_q    <= cpu_be;
          sel_q   <= hit;
          err_q   <= !found;
          rdata_q <= '0;
          cnt     <= '0;
        end
        S_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (ack_hit) begin
            rdata_q <= rd_mux;
            err_q   <= 1'b0;
          end else if (tmo) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dev_sel   = in_acc ? sel_q : '0;
  assign dev_we    = in_acc & we_q;
  assign dev_addr  = in_acc ? addr_q : '0;
  assign dev_wdata = in_acc ? wdata_q : '0;
  assign dev_be    = in_acc ? be_q : '0;

  assign cpu_ready = (state == S_RESP);
  assign cpu_err   = cpu_ready & err_q;
  assign cpu_rdata = (cpu_ready && !err_q && !we_q) ? rdata_q : '0;

  assign clr = (cpu_ready && !err_q) ? sel_q : '0;

  irq_latch_n #(.NUM_DEV(NUM_DEV), .IRQ_EDGE(IRQ_EDGE)) u_irq (
    .clk    (clk),
    .reset  (reset),
    .irq_in (dev_irq),
    .clr    (clr),
    .irq    (irq_dev)
  );

  always_comb begin
    irq_out              = '0;
    irq_out[NUM_DEV-1:0] = irq_dev;
  end

endmodule

// File: tb/tb_sys_bridge_n.sv
// Self-checking bench for sys_bridge_n: directed vector table, random accesses
// against an address-map model, IRQ timing and reset-abandon sequences.
module tb_sys_bridge_n;

  localparam int          ND   = 4;
  localparam logic [31:0] BASE = 32'h0000_7F00;
  localparam logic [31:0] STR  = 32'h10;
  localparam int          WIN  = 12;
  localparam int          WR   = 8;
  localparam int          TO   = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]    cpu_be;
  logic          cpu_ready, cpu_err;
  logic [5:0]    irq_out;
  logic [ND-1:0] dev_sel, dev_ack, dev_irq, noise;
  logic          dev_we;
  logic [3:0]    dev_addr, dev_be;
  logic [31:0]   dev_wdata;
  logic [32*ND-1:0] dev_rdata;

  logic [31:0] drd [ND] = '{32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_2222, 32'h3333_3333};
  int  dly;
  int  sel_cnt;
  bit  noise_en;
  int  checks, errors;

  sys_bridge_n #(.NUM_DEV(ND), .TIMEOUT(TO), .IRQ_EDGE(4'b0001)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .irq_out(irq_out), .dev_sel(dev_sel), .dev_we(dev_we),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_be(dev_be), .dev_rdata(dev_rdata),
    .dev_ack(dev_ack), .dev_irq(dev_irq)
  );

  always #5 clk = ~clk;

  assign dev_rdata = {drd[3], drd[2], drd[1], drd[0]};

  // Device model: selected device acks after dly extra cycles (dly<0 never acks);
  // unselected devices may chatter random acks that must be ignored.
  always @(posedge clk) sel_cnt <= (dev_sel != 0) ? sel_cnt + 1 : 0;
  always @(negedge clk) noise <= noise_en ? ND'($urandom) : '0;

  always_comb begin
    dev_ack = noise & ~dev_sel;
    for (int i = 0; i < ND; i++)
      if (dev_sel[i] && dly >= 0 && sel_cnt == dly) dev_ack[i] = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference address map: device i owns [BASE+i*STR, BASE+i*STR+span) in wide arithmetic.
  function automatic int model_dev(input bit we, input logic [31:0] a);
    longint unsigned aa, lo, span;
    model_dev = -1;
    aa   = {32'h0, a};
    span = we ? WR : WIN;
    for (int i = 0; i < ND; i++) begin
      lo = {32'h0, BASE} + longint'(i) * {32'h0, STR};
      if (aa >= lo && aa < lo + span) model_dev = i;
    end
  endfunction

  task automatic access(input string nm, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be, input logic [3:0] exp_sel,
                        input int exp_selc, input bit exp_err, input logic [31:0] exp_rd);
    int cyc, selc;
    bit done, bad;
    logic err_s;
    logic [31:0] rd_s;
    cyc = 0; selc = 0; done = 0; bad = 0; err_s = 0; rd_s = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_be = be;
    while (!done && cyc < 64) begin
      tick();
      cyc++;
      if (dev_sel != 0) begin
        selc++;
        if (dev_sel !== exp_sel || dev_addr !== a[3:0] || dev_we !== we ||
            dev_be !== be || (we && dev_wdata !== wd)) bad = 1;
      end
      if (cpu_ready) begin
        done = 1; err_s = cpu_err; rd_s = cpu_rdata; cpu_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    chk({nm, "_done"},  32'(done), 32'd1);
    chk({nm, "_lat"},   32'(cyc), 32'(exp_selc + 1));
    chk({nm, "_selc"},  32'(selc), 32'(exp_selc));
    chk({nm, "_bus"},   32'(bad), 32'd0);
    chk({nm, "_err"},   32'(err_s), 32'(exp_err));
    chk({nm, "_rdata"}, rd_s, exp_rd);
    tick();
    chk({nm, "_pulse"}, 32'(cpu_ready), 32'd0);
  endtask

  typedef struct {
    int          dly;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [3:0]  sel;
    int          selc;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [12];

  initial begin
    int dv, cnt_rdy;
    logic [31:0] a;
    bit we;

    vt[0]  = '{2,  1'b0, 32'h7F14, 32'h0,        4'hF, 4'b0010, 3,  1'b0, 32'hDEAD_BEEF};
    vt[1]  = '{0,  1'b1, 32'h7F08, 32'h1234,     4'hF, 4'b0000, 0,  1'b1, 32'h0};
    vt[2]  = '{0,  1'b0, 32'h7F08, 32'h0,        4'hF, 4'b0001, 1,  1'b0, 32'h1111_0000};
    vt[3]  = '{0,  1'b0, 32'h7F4C, 32'h0,        4'hF, 4'b0000, 0,  1'b1, 32'h0};
    vt[4]  = '{0,  1'b0, 32'h6000, 32'h0,        4'hF, 4'b0000, 0,  1'b1, 32'h0};
    vt[5]  = '{-1, 1'b0, 32'h7F20, 32'h0,        4'hF, 4'b0100, 16, 1'b1, 32'h0};
    vt[6]  = '{1,  1'b1, 32'h7F24, 32'hCAFE_0001, 4'h3, 4'b0100, 2,  1'b0, 32'h0};
    vt[7]  = '{0,  1'b0, 32'h7F3B, 32'h0,        4'hF, 4'b1000, 1,  1'b0, 32'h3333_3333};
    vt[8]  = '{0,  1'b0, 32'h7F0C, 32'h0,        4'hF, 4'b0000, 0,  1'b1, 32'h0};
    vt[9]  = '{0,  1'b1, 32'h7F37, 32'h55AA_55AA, 4'h8, 4'b1000, 1,  1'b0, 32'h0};
    vt[10] = '{15, 1'b0, 32'h7F10, 32'h0,        4'hF, 4'b0010, 16, 1'b0, 32'hDEAD_BEEF};
    vt[11] = '{0,  1'b0, 32'h7EFF, 32'h0,        4'hF, 4'b0000, 0,  1'b1, 32'h0};

    checks = 0; errors = 0; dly = 0; noise_en = 0;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_be = 0; dev_irq = 0;
    repeat (3) tick();
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_wdata", dev_wdata, 32'h0);
    chk("rst_ctl", 32'({cpu_ready, cpu_err, irq_out, dev_sel, dev_we, dev_addr, dev_be}), 32'h0);
    reset = 1'b0;
    tick();

    foreach (vt[n]) begin
      dly = vt[n].dly;
      access($sformatf("vec%0d", n), vt[n].we, vt[n].addr, vt[n].wd, vt[n].be,
             vt[n].sel, vt[n].selc, vt[n].err, vt[n].rd);
    end

    // Random accesses with spurious acks from unselected devices.
    noise_en = 1;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      case ($urandom_range(0, 7))
        0:       a = $urandom;
        1:       a = BASE - 32'($urandom_range(1, 16));
        default: a = BASE + 32'($urandom_range(0, 5)) * STR + 32'($urandom_range(0, 15));
      endcase
      dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      dv  = model_dev(we, a);
      access($sformatf("rnd%0d", n), we, a, $urandom, 4'($urandom),
             (dv >= 0) ? 4'(1 << dv) : 4'h0,
             (dv < 0) ? 0 : ((dly < 0) ? TO : dly + 1),
             (dv < 0) || (dly < 0),
             (dv >= 0 && dly >= 0 && !we) ? drd[dv] : 32'h0);
    end
    noise_en = 0;
    dly = 0;
    tick();

    // IRQ: one-cycle pulse on edge device 0, 5-cycle level on device 1.
    dev_irq = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) dev_irq[0] = 1'b0;
      if (k == 5) dev_irq[1] = 1'b0;
      chk($sformatf("irq_t%0d", k), 32'(irq_out),
          32'({4'b0000, (k >= 2 && k <= 6) ? 1'b1 : 1'b0, (k >= 2) ? 1'b1 : 1'b0}));
    end
    access("irq_err0", 1'b1, 32'h7F08, 32'h1, 4'hF, 4'h0, 0, 1'b1, 32'h0);
    chk("irq_keep_err", 32'(irq_out), 32'h01);
    access("irq_dev1", 1'b0, 32'h7F10, 32'h0, 4'hF, 4'b0010, 1, 1'b0, 32'hDEAD_BEEF);
    chk("irq_keep_oth", 32'(irq_out), 32'h01);
    access("irq_clr", 1'b0, 32'h7F00, 32'h0, 4'hF, 4'b0001, 1, 1'b0, 32'h1111_0000);
    chk("irq_cleared", 32'(irq_out), 32'h00);

    // New edge in the same cycle as the clear keeps the latch set.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F04; cpu_be = 4'hF;
    tick();
    dev_irq[0] = 1'b1;
    tick();
    chk("race_ready", 32'(cpu_ready), 32'd1);
    cpu_req = 1'b0;
    dev_irq[0] = 1'b0;
    tick();
    chk("race_irq", 32'(irq_out), 32'h01);

    // Reset in the middle of a device 3 access abandons it.
    dly = -1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F30; cpu_be = 4'hF;
    tick();
    tick();
    chk("mid_sel", 32'(dev_sel), 32'h8);
    reset = 1'b1;
    tick();
    chk("mid_rst_ctl", 32'({cpu_ready, cpu_err, irq_out, dev_sel, dev_we, dev_addr, dev_be}), 32'h0);
    chk("mid_rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b0;
    cpu_req = 1'b0;
    cnt_rdy = 0;
    repeat (20) begin
      tick();
      if (cpu_ready) cnt_rdy++;
    end
    chk("mid_no_ready", 32'(cnt_rdy), 32'd0);
    dly = 0;
    access("post_rst", 1'b0, 32'h7F04, 32'h0, 4'hF, 4'b0001, 1, 1'b0, 32'h1111_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
